// File: rtl/pixel_out_stage.sv
// pixel_out_stage
//   Output stage behind the second pixel-processing block. Buffers 24-bit
//   pixels in a small first-word-fall-through FIFO and presents them on a
//   valid/ready stream. Each pixel is tagged with raster position flags
//   derived from column/row counters that advance on every pop.
//
// Ports
//   cp           clock, rising edge
//   reset        asynchronous active-low reset
//   in_pixel     upstream pixel
//   in_valid     upstream strobe, in_pixel valid this cycle
//   in_ready     registered space-available indication
//   frame_abort  synchronous flush of FIFO, raster counters and overflow
//   out_pixel    head-of-FIFO pixel (0 while empty)
//   out_valid    FIFO non-empty
//   out_ready    downstream accepts the head pixel
//   out_sol/eol  head pixel is first/last column of its line
//   out_sof/eof  head pixel is first/last pixel of the frame
//   fill_level   current occupancy
//   overflow     sticky: in_valid seen while in_ready was low
module pixel_out_stage #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned LINE_PIXELS = 640,
  parameter int unsigned FRAME_LINES = 480
) (
  input  logic                       cp,
  input  logic                       reset,
  input  logic [23:0]                in_pixel,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       frame_abort,
  output logic [23:0]                out_pixel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sol,
  output logic                       out_eol,
  output logic                       out_sof,
  output logic                       out_eof,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic                       overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned ColW = $clog2(LINE_PIXELS);
  localparam int unsigned RowW = $clog2(FRAME_LINES);

  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [ColW-1:0] ColLast = ColW'(LINE_PIXELS - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(FRAME_LINES - 1);

  logic [23:0]     r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic [ColW-1:0] r_col;
  logic [RowW-1:0] r_row;
  logic            r_in_ready;
  logic            r_overflow;

  logic            w_out_valid;
  logic            w_push;
  logic            w_pop;
  logic [CntW-1:0] w_count_nxt;

  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid & r_in_ready;
  assign w_pop       = w_out_valid & out_ready;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Data array carries no reset; only occupancy decides what is visible.
  always_ff @(posedge cp) begin
    if (reset && !frame_abort && w_push) begin
      r_mem[r_wr_ptr] <= in_pixel;
    end
  end

  always_ff @(posedge cp or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_in_ready <= 1'b1;
      r_overflow <= 1'b0;
    end else if (frame_abort) begin
      // Abort wins over any push/pop in the same cycle.
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_in_ready <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + 1'b1;
        if (r_col == ColLast) begin
          r_col <= '0;
          r_row <= (r_row == RowLast) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      r_count    <= w_count_nxt;
      // Registered, so a pop while full frees space only from the next cycle.
      r_in_ready <= (w_count_nxt != CntFull);
      if (in_valid && !r_in_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = w_out_valid;
  assign fill_level = r_count;
  assign overflow   = r_overflow;

  // Pixel and flags are forced low while empty so reset shows a clean bus.
  assign out_pixel = w_out_valid ? r_mem[r_rd_ptr] : 24'h0;
  assign out_sol   = w_out_valid & (r_col == '0);
  assign out_eol   = w_out_valid & (r_col == ColLast);
  assign out_sof   = out_sol & (r_row == '0);
  assign out_eof   = out_eol & (r_row == RowLast);

endmodule
